// File: rtl/dmd_frame_photon_counter_if.sv
// Bus between the SPI-side controller / detector pins and the per-frame photon counter.
// The master modport drives the arm level and the raw pins; the slave modport is the counter.
interface dmd_frame_photon_counter_if #(
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 10
);
    logic              enable;
    logic              sig;
    logic              DMD_sig;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [CNT_W-1:0]  wr_data;
    logic              busy;
    logic              done;
    logic              overflow;

    modport master (
        output enable, sig, DMD_sig,
        input  wr_en, wr_addr, wr_data, busy, done, overflow
    );

    modport slave (
        input  enable, sig, DMD_sig,
        output wr_en, wr_addr, wr_data, busy, done, overflow
    );
endinterface

// File: rtl/dmd_frame_photon_counter.sv
// Counts synchronised photon edges inside each DMD pattern window and writes {frame, count} at window close.
// DMD pin to wr_en is SYNC_STAGES+2 cycles; no backpressure, one write strobe per closed frame.
module dmd_frame_photon_counter #(
    parameter int CNT_W        = 16,
    parameter int ADDR_W       = 10,
    parameter int NUM_FRAMES   = 1000,
    parameter int SYNC_STAGES  = 2,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    dmd_frame_photon_counter_if.slave     bus
);
    localparam int GW = $clog2(GUARD_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FIRST,
        S_GUARD,
        S_COUNT,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sig_sync;
    logic [SYNC_STAGES-1:0] r_dmd_sync;
    logic                   r_sig_prev;
    logic                   r_dmd_prev;
    logic                   r_sig_evt;
    logic                   r_dmd_evt;
    logic [CNT_W-1:0]       r_count;
    logic [ADDR_W-1:0]      r_frame;
    logic [GW-1:0]          r_guard;
    logic                   r_wr_en;
    logic [ADDR_W-1:0]      r_wr_addr;
    logic [CNT_W-1:0]       r_wr_data;
    logic                   r_overflow;

    logic                   w_clear;
    logic                   w_load_guard;
    logic                   w_close;
    logic                   w_count_ph;
    logic                   w_sat;
    logic                   w_last;
    logic [CNT_W-1:0]       w_cnt_inc;
    logic [CNT_W-1:0]       w_close_data;
    logic [ADDR_W:0]        w_frame_inc;

    assign w_sat        = &r_count;
    assign w_cnt_inc    = w_sat ? r_count : r_count + CNT_W'(1);
    assign w_close_data = r_sig_evt ? w_cnt_inc : r_count;
    assign w_frame_inc  = {1'b0, r_frame} + (ADDR_W+1)'(1);
    assign w_last       = (w_frame_inc == (ADDR_W+1)'(NUM_FRAMES));

    // Edge pulses are registered, so the FSM sees each edge SYNC_STAGES+1 cycles after the pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig_sync <= '0;
            r_dmd_sync <= '0;
            r_sig_prev <= 1'b0;
            r_dmd_prev <= 1'b0;
            r_sig_evt  <= 1'b0;
            r_dmd_evt  <= 1'b0;
        end else begin
            r_sig_sync <= {r_sig_sync[SYNC_STAGES-2:0], bus.sig};
            r_dmd_sync <= {r_dmd_sync[SYNC_STAGES-2:0], bus.DMD_sig};
            r_sig_prev <= r_sig_sync[SYNC_STAGES-1];
            r_dmd_prev <= r_dmd_sync[SYNC_STAGES-1];
            r_sig_evt  <= r_sig_sync[SYNC_STAGES-1] & ~r_sig_prev;
            r_dmd_evt  <= r_dmd_sync[SYNC_STAGES-1] & ~r_dmd_prev;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_clear      = 1'b0;
        w_load_guard = 1'b0;
        w_close      = 1'b0;
        w_count_ph   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_clear = 1'b1;
                if (bus.enable) w_state_nxt = S_WAIT_FIRST;
            end
            S_WAIT_FIRST: begin
                if (!bus.enable) begin
                    w_state_nxt = S_IDLE;
                end else if (r_dmd_evt) begin
                    w_state_nxt  = S_GUARD;
                    w_load_guard = 1'b1;
                end
            end
            S_GUARD: begin
                if (!bus.enable)        w_state_nxt = S_IDLE;
                else if (r_guard == '0) w_state_nxt = S_COUNT;
            end
            S_COUNT: begin
                // Abort wins over a coinciding close so a dropped run never writes.
                if (!bus.enable) begin
                    w_state_nxt = S_IDLE;
                end else if (r_dmd_evt) begin
                    w_close      = 1'b1;
                    w_state_nxt  = w_last ? S_DONE : S_GUARD;
                    w_load_guard = !w_last;
                end else if (r_sig_evt) begin
                    w_count_ph = 1'b1;
                end
            end
            S_DONE: begin
                if (!bus.enable) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= '0;
            r_frame    <= '0;
            r_guard    <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_en <= w_close;
            if (w_clear) begin
                r_count    <= '0;
                r_frame    <= '0;
                r_overflow <= 1'b0;
            end
            if (w_load_guard) begin
                r_guard <= GW'(GUARD_CYCLES - 1);
                r_count <= '0;
            end else if (r_state == S_GUARD && r_guard != '0) begin
                r_guard <= r_guard - GW'(1);
            end
            if (w_count_ph) begin
                r_count <= w_cnt_inc;
                if (w_sat) r_overflow <= 1'b1;
            end
            if (w_close) begin
                r_wr_addr <= r_frame;
                r_wr_data <= w_close_data;
                r_frame   <= w_frame_inc[ADDR_W-1:0];
                if (r_sig_evt && w_sat) r_overflow <= 1'b1;
            end
        end
    end

    assign bus.wr_en    = r_wr_en;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign bus.overflow = r_overflow;
    assign bus.busy     = (r_state == S_WAIT_FIRST) || (r_state == S_GUARD) || (r_state == S_COUNT);
    assign bus.done     = (r_state == S_DONE);
endmodule

// File: tb/tb_dmd_frame_photon_counter.sv
// Bench for dmd_frame_photon_counter: table-driven frame runs, hand-written corner sequences, random runs.
module tb_dmd_frame_photon_counter;
    localparam int CW = 4;
    localparam int AW = 4;
    localparam int NF = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    dmd_frame_photon_counter_if #(.CNT_W(CW), .ADDR_W(AW)) bus ();

    dmd_frame_photon_counter #(
        .CNT_W(CW), .ADDR_W(AW), .NUM_FRAMES(NF), .SYNC_STAGES(2), .GUARD_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct { int addr; int data; } wr_t;
    wr_t wq[$];
    int  run_len = 0;
    int  wide    = 0;

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wq.push_back('{int'(bus.wr_addr), int'(bus.wr_data)});
            run_len++;
            if (run_len > 1) wide++;
        end else begin
            run_len = 0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
        end
    endtask

    task automatic dmd_pulse();
        bus.DMD_sig = 1'b1;
        cyc(2);
        bus.DMD_sig = 1'b0;
        cyc(4);
    endtask

    task automatic photons(input int n);
        for (int i = 0; i < n; i++) begin
            bus.sig = 1'b1;
            cyc(2);
            bus.sig = 1'b0;
            cyc(2 + int'($urandom_range(0, 2)));
        end
    endtask

    task automatic check_writes(input string nm, input int nexp, input int e0, input int e1, input int e2);
        int e[3];
        e = '{e0, e1, e2};
        chk({nm, "_nwr"}, wq.size(), nexp);
        for (int i = 0; i < nexp && i < wq.size(); i++) begin
            chk({nm, "_addr"}, wq[i].addr, i);
            chk({nm, "_data"}, wq[i].data, e[i]);
        end
        wq.delete();
    endtask

    // Arms from IDLE, runs three full windows and checks the writes; leaves enable high.
    task automatic run_and_check(input string nm, input int p0, input int p1, input int p2,
                                 input int d0, input int d1, input int d2, input int ovf);
        bus.enable = 1'b1;
        cyc(2);
        chk({nm, "_ovf_arm"}, bus.overflow, 0);
        chk({nm, "_busy_arm"}, bus.busy, 1);
        dmd_pulse();
        photons(p0);
        dmd_pulse();
        photons(p1);
        dmd_pulse();
        photons(p2);
        dmd_pulse();
        cyc(6);
        check_writes(nm, NF, d0, d1, d2);
        chk({nm, "_done"}, bus.done, 1);
        chk({nm, "_busy"}, bus.busy, 0);
        chk({nm, "_ovf"}, bus.overflow, ovf);
    endtask

    task automatic disarm(input string nm);
        bus.enable = 1'b0;
        cyc(3);
        chk({nm, "_done_off"}, bus.done, 0);
        chk({nm, "_busy_off"}, bus.busy, 0);
    endtask

    typedef struct { int p0, p1, p2; int d0, d1, d2; int ovf; } vec_t;
    vec_t tbl[5];

    initial begin
        int p[3];
        int ovf;

        bus.enable  = 1'b0;
        bus.sig     = 1'b0;
        bus.DMD_sig = 1'b0;

        tbl[0] = '{4, 0, 7, 4, 0, 7, 0};
        tbl[1] = '{20, 1, 3, 15, 1, 3, 1};
        tbl[2] = '{15, 16, 0, 15, 15, 0, 1};
        tbl[3] = '{15, 0, 14, 15, 0, 14, 0};
        tbl[4] = '{0, 0, 0, 0, 0, 0, 0};

        cyc(3);
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_ovf", bus.overflow, 0);
        rst = 1'b0;
        cyc(3);

        for (int i = 0; i < 5; i++) begin
            run_and_check($sformatf("tbl%0d", i), tbl[i].p0, tbl[i].p1, tbl[i].p2,
                          tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].ovf);
            disarm($sformatf("tbl%0d", i));
        end

        // Leave a nonzero last write behind, then reset in the middle of a counting frame.
        run_and_check("pre_rst", 1, 2, 3, 1, 2, 3, 0);
        disarm("pre_rst");
        bus.enable = 1'b1;
        cyc(2);
        dmd_pulse();
        photons(5);
        rst = 1'b1;
        cyc(1);
        chk("midrst_wr_en", bus.wr_en, 0);
        chk("midrst_wr_addr", bus.wr_addr, 0);
        chk("midrst_wr_data", bus.wr_data, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_done", bus.done, 0);
        chk("midrst_ovf", bus.overflow, 0);
        bus.enable = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(4);
        check_writes("midrst", 0, 0, 0, 0);
        chk("midrst_busy_after", bus.busy, 0);

        // Photon inside the guard is dropped; photon coinciding with the closing edge is kept.
        bus.enable = 1'b1;
        cyc(2);
        bus.DMD_sig = 1'b1;
        cyc(1);
        bus.sig = 1'b1;
        cyc(1);
        bus.DMD_sig = 1'b0;
        cyc(1);
        bus.sig = 1'b0;
        cyc(4);
        photons(2);
        dmd_pulse();
        bus.DMD_sig = 1'b1;
        bus.sig     = 1'b1;
        cyc(2);
        bus.DMD_sig = 1'b0;
        bus.sig     = 1'b0;
        cyc(4);
        photons(3);
        dmd_pulse();
        cyc(6);
        check_writes("guard_coinc", NF, 2, 1, 3);
        chk("guard_coinc_done", bus.done, 1);
        disarm("guard_coinc");

        // Abort after two closed frames, then re-arm and expect a fresh run from frame 0.
        bus.enable = 1'b1;
        cyc(2);
        dmd_pulse();
        photons(2);
        dmd_pulse();
        photons(1);
        dmd_pulse();
        photons(3);
        bus.enable = 1'b0;
        cyc(6);
        check_writes("abort", 2, 2, 1, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        run_and_check("rearm", 3, 2, 1, 3, 2, 1, 0);

        // Enable still high in DONE: further edges are ignored until enable toggles.
        for (int i = 0; i < 3; i++) begin
            dmd_pulse();
            photons(2);
        end
        cyc(4);
        check_writes("done_hold", 0, 0, 0, 0);
        chk("done_hold_done", bus.done, 1);
        chk("done_hold_busy", bus.busy, 0);
        disarm("done_hold");
        run_and_check("restart", 5, 0, 2, 5, 0, 2, 0);
        disarm("restart");

        for (int r = 0; r < 8; r++) begin
            ovf = 0;
            for (int k = 0; k < 3; k++) begin
                p[k] = int'($urandom_range(0, 20));
                if (p[k] > CMAX) ovf = 1;
            end
            run_and_check($sformatf("rnd%0d", r), p[0], p[1], p[2],
                          (p[0] > CMAX) ? CMAX : p[0],
                          (p[1] > CMAX) ? CMAX : p[1],
                          (p[2] > CMAX) ? CMAX : p[2], ovf);
            disarm($sformatf("rnd%0d", r));
        end

        chk("wr_en_width", wide, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmd_frame_photon_counter.md
Name: dmd_frame_photon_counter

Overview:
- Upstream stage feeding DataMemory: counts photon pulses on sig within each DMD pattern window. A window is delimited by consecutive DMD_sig rising edges.
- At every window close it issues a one-cycle write of {frame index, photon count} toward memory.
- It is armed and disarmed by the SPI controller through enable, and raises done after NUM_FRAMES windows.
- Replaces the free-running counter/reset handshake with an explicit per-frame write interface.

Parameters:
- CNT_W, 16, photon count width (saturating).
- ADDR_W, 10, frame index / write address width.
- NUM_FRAMES, 1000, windows per acquisition; must satisfy 1 <= NUM_FRAMES <= 2^ADDR_W.
- SYNC_STAGES, 2, synchroniser flops on sig and DMD_sig (>= 2).
- GUARD_CYCLES, 2, clk cycles after each DMD edge during which photon edges are ignored (>= 1).

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  level arm from controller; 1 = acquire, 0 = abort/idle.
- sig  in  1  asynchronous photon pulse from detector.
- DMD_sig  in  1  asynchronous DMD pattern trigger.
- wr_en  out  1  one-cycle write strobe.
- wr_addr  out  ADDR_W  frame index for the write.
- wr_data  out  CNT_W  photon count of the closed frame.
- busy  out  1  high in WAIT_FIRST, GUARD or COUNT.
- done  out  1  high in DONE.
- overflow  out  1  sticky: some frame of this run saturated.

Behaviour:
- Reset (async, any state): state = IDLE; synchronisers, edge registers, count, frame index cleared; wr_en = busy = done = overflow = 0; wr_addr = wr_data = 0.
- Synchronisation: sig and DMD_sig each pass through SYNC_STAGES flops, then a registered previous-value flop. A rising edge is sync = 1 with prev = 0, giving one pulse per edge.
- Pin-to-event latency is SYNC_STAGES + 1 cycles.
- Pulses shorter than one clk period may be missed; this is acceptable.
- IDLE:
  - On enable = 1, go to WAIT_FIRST.
  - On entry, clear count, frame index and overflow.
- WAIT_FIRST:
  - Photon edges are ignored.
  - The first DMD edge goes to GUARD with count = 0 and the guard counter loaded.
- GUARD:
  - Lasts exactly GUARD_CYCLES cycles, then goes to COUNT.
  - Photon edges and DMD edges are ignored (DMD edge debounce).
- COUNT, on a photon edge:
  - count = count + 1, saturating at 2^CNT_W - 1.
  - If count is already saturated, set overflow.
- COUNT, on a DMD edge (frame close):
  - Next cycle: wr_en = 1 for exactly one cycle, wr_addr = frame index, wr_data = final count.
  - A photon edge in the same cycle as the closing DMD edge is included in wr_data.
  - Frame index then increments.
  - If the incremented index equals NUM_FRAMES, go to DONE.
  - Otherwise go to GUARD with count = 0.
- DONE:
  - done = 1, busy = 0.
  - Holds until enable = 0, then goes to IDLE.
  - All input edges are ignored.
- Abort: enable = 0 in WAIT_FIRST, GUARD or COUNT goes to IDLE on the next cycle. No write is issued; the partial count is discarded.
- DMD edge to wr_en latency: SYNC_STAGES + 2 cycles from the pin.
- wr_addr and wr_data hold their last written values while wr_en = 0 and clear only on reset.
- wr_en is never asserted outside the COUNT-to-close transition.
- Exactly NUM_FRAMES writes occur per completed run, at addresses 0 .. NUM_FRAMES-1 in order.
- Re-arm after DONE requires enable to go 0 then 1. Holding enable at 1 in DONE does not restart.
- Mid-operation reset behaves identically to power-on reset; no write is produced.

Test Plan:
- Reset/idle: assert rst mid-COUNT with 5 photons counted -> all outputs 0, state IDLE, no wr_en.
- Basic frames (NUM_FRAMES = 3, GUARD_CYCLES = 2): arm, DMD edge, 4 photons, DMD edge, 0 photons, DMD edge, 7 photons, DMD edge -> writes (0,4), (1,0), (2,7), each wr_en one cycle wide; then done = 1, busy = 0.
- Guard/coincidence:
  - Photon edge 1 cycle after a DMD edge (inside guard) -> not counted.
  - Photon edge in the same synchronised cycle as the closing DMD edge -> counted (wr_data = 1).
- Saturation (CNT_W = 4): 20 photons in one frame -> wr_data = 15, overflow = 1.
  - Overflow stays 1 through later frames.
  - Overflow clears on the next arm.
- Abort: drop enable after 2 of 3 frames -> exactly 2 writes, no third write, busy = 0, done = 0.
  - Re-arm -> next write has wr_addr = 0.
- DONE hold: keep enable = 1 after done and apply 3 more DMD edges -> no writes, done stays 1.
  - Toggling enable 0 -> 1 restarts from frame 0.
